// File: rtl/wb_arbiter_pkg.sv
// Shared types and sizing for the register-file write-back arbiter.
package wb_arbiter_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NREG       = 32;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned STARVE_MAX = 8;

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // One-hot register select; x0 maps to no bit so it can never be tracked.
  function automatic logic [NREG-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    return (r == '0) ? '0 : (NREG'(1) << r);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: ALU/LU result inputs, decode hazard query, register-file write port.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
();

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  lu_issue;
  logic [REG_ADDR_W-1:0] lu_issue_rd;
  logic                  lu_valid;
  logic                  lu_ready;
  logic [REG_ADDR_W-1:0] lu_rd;
  logic [XLEN-1:0]       lu_data;
  logic [REG_ADDR_W-1:0] chk_rs1;
  logic [REG_ADDR_W-1:0] chk_rs2;
  logic [REG_ADDR_W-1:0] chk_rd;
  logic                  hazard;
  logic                  alu_stall;
  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] addD;
  logic [XLEN-1:0]       WB_out;
  logic [NREG-1:0]       busy_mask;
  logic                  fifo_full;
  logic                  err_sticky;

  modport slave (
    input  alu_valid, alu_rd, alu_data, lu_issue, lu_issue_rd,
           lu_valid, lu_rd, lu_data, chk_rs1, chk_rs2, chk_rd,
    output lu_ready, hazard, alu_stall, RegWrite, addD, WB_out,
           busy_mask, fifo_full, err_sticky
  );

  modport master (
    output alu_valid, alu_rd, alu_data, lu_issue, lu_issue_rd,
           lu_valid, lu_rd, lu_data, chk_rs1, chk_rs2, chk_rd,
    input  lu_ready, hazard, alu_stall, RegWrite, addD, WB_out,
           busy_mask, fifo_full, err_sticky
  );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// Small LU result buffer; power-of-two depth so pointers wrap naturally.
module wb_fifo
  import wb_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        wdata,
  input  logic             pop,
  output wb_entry_t        rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and buffered LU results onto the single register-file write port,
// tracks pending LU destinations and raises decode hazards against them.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  wb_entry_t        lu_entry, head, win;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             sel_alu;

  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] add_d_q, add_d_d;
  logic [XLEN-1:0]       wb_out_q, wb_out_d;
  logic [NREG-1:0]       busy_q, busy_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  alu_stall_q, alu_stall_d;
  logic                  err_q, err_d;

  always_comb begin
    lu_entry.rd   = bus.lu_rd;
    lu_entry.data = bus.lu_data;
  end

  assign fifo_push = bus.lu_valid && !fifo_full;

  wb_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (lu_entry),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Arbitration, scoreboard update and starvation tracking.
  always_comb begin
    sel_alu     = !alu_stall_q && bus.alu_valid;
    fifo_pop    = !fifo_empty && (alu_stall_q || !bus.alu_valid);
    win.rd      = bus.alu_rd;
    win.data    = bus.alu_data;
    if (!sel_alu) win = head;

    reg_write_d = (sel_alu || fifo_pop) && (win.rd != '0);
    add_d_d     = win.rd;
    wb_out_d    = win.data;

    // Clear before set so a same-edge re-issue keeps the register busy.
    busy_d = busy_q;
    if (fifo_pop)     busy_d = busy_d & ~reg_onehot(head.rd);
    if (bus.lu_issue) busy_d = busy_d | reg_onehot(bus.lu_issue_rd);

    starve_d = starve_q;
    if (fifo_empty || fifo_pop) starve_d = '0;
    else if (sel_alu)           starve_d = starve_q + STARVE_W'(1);

    alu_stall_d = (starve_d == STARVE_W'(STARVE_MAX));
    err_d       = err_q || (alu_stall_q && bus.alu_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      add_d_q     <= '0;
      wb_out_q    <= '0;
      busy_q      <= '0;
      starve_q    <= '0;
      alu_stall_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      reg_write_q <= reg_write_d;
      add_d_q     <= add_d_d;
      wb_out_q    <= wb_out_d;
      busy_q      <= busy_d;
      starve_q    <= starve_d;
      alu_stall_q <= alu_stall_d;
      err_q       <= err_d;
    end
  end

  assign bus.hazard     = |(busy_q & (reg_onehot(bus.chk_rs1) |
                                      reg_onehot(bus.chk_rs2) |
                                      reg_onehot(bus.chk_rd)));
  assign bus.lu_ready   = !fifo_full;
  assign bus.fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign bus.alu_stall  = alu_stall_q;
  assign bus.RegWrite   = reg_write_q;
  assign bus.addD       = add_d_q;
  assign bus.WB_out     = wb_out_q;
  assign bus.busy_mask  = busy_q;
  assign bus.err_sticky = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register writes are queued at stimulus
// time and matched by a monitor; status outputs are checked inline.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if bus();

  wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_wr(input int c, input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.rd = rd; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lu_issue = 0;  bus.lu_issue_rd = '0;
    bus.lu_valid = 0;  bus.lu_rd = '0;  bus.lu_data = '0;
    bus.chk_rs1 = '0;  bus.chk_rs2 = '0; bus.chk_rd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every register-file write must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (bus.RegWrite !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addD=%0d data=%h (cycle %0d)", bus.addD, bus.WB_out, cyc);
      end else begin
        e = exp_q.pop_front();
        check("wr_en", 32'(bus.RegWrite), 32'd1);
        check("wr_addD", 32'(bus.addD), 32'(e.rd));
        check("wr_data", bus.WB_out, e.data);
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int base;
    int idx;
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_regwrite", 32'(bus.RegWrite), 0);
    check("rst_busy", bus.busy_mask, 0);
    check("rst_full", 32'(bus.fifo_full), 0);
    check("rst_stall", 32'(bus.alu_stall), 0);
    check("rst_err", 32'(bus.err_sticky), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_lu_ready", 32'(bus.lu_ready), 1);

    // 1: single ALU write
    tick();
    bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    expect_wr(cyc + 1, 5'd5, 32'hDEADBEEF);
    tick();
    idle();

    // 2: LU issue, hazard, result write-back 2 cycles after handshake
    tick();
    bus.lu_issue = 1; bus.lu_issue_rd = 5'd7; bus.chk_rs1 = 5'd7;
    #1;
    check("haz_no_bypass", 32'(bus.hazard), 0);
    tick();
    bus.lu_issue = 0;
    @(negedge clk);
    check("haz_set", 32'(bus.hazard), 1);
    check("busy7_set", bus.busy_mask, 32'h0000_0080);
    bus.lu_valid = 1; bus.lu_rd = 5'd7; bus.lu_data = 32'h1234;
    expect_wr(cyc + 2, 5'd7, 32'h1234);
    tick();
    bus.lu_valid = 0;
    @(negedge clk);
    check("busy7_pending", bus.busy_mask, 32'h0000_0080);
    tick();
    @(negedge clk);
    check("busy7_clr", bus.busy_mask, 0);
    check("haz_clr", 32'(bus.hazard), 0);
    idle();

    // 3/4: ALU hogs the port while LU fills the FIFO; starvation forces one pop
    tick();
    base = cyc;
    for (int k = 1; k <= 14; k++) begin
      idx = (k <= 4) ? k - 1 : 4;
      bus.alu_valid = (k <= 10);
      bus.alu_rd    = 5'(k);
      bus.alu_data  = 32'hA000_0000 | 32'(k);
      bus.lu_valid  = (k <= 11);
      bus.lu_rd     = 5'(20 + idx);
      bus.lu_data   = 32'hB000_0000 | 32'(idx);
      if (k <= 9) expect_wr(base + k, 5'(k), 32'hA000_0000 | 32'(k));
      if (k >= 10) expect_wr(base + k, 5'(10 + k), 32'hB000_0000 | 32'(k - 10));
      @(posedge clk);
      @(negedge clk);
      if (k == 4) begin
        check("full_after4", 32'(bus.fifo_full), 1);
        check("lu_ready_full", 32'(bus.lu_ready), 0);
      end
      if (k == 8) check("no_stall_at7", 32'(bus.alu_stall), 0);
      if (k == 9) begin
        check("stall_set", 32'(bus.alu_stall), 1);
        check("err_before", 32'(bus.err_sticky), 0);
      end
      if (k == 10) begin
        check("stall_clr", 32'(bus.alu_stall), 0);
        check("err_set", 32'(bus.err_sticky), 1);
        check("full_after_pop", 32'(bus.fifo_full), 0);
      end
      if (k == 14) check("drained_ready", 32'(bus.lu_ready), 1);
    end
    idle();
    tick();
    check("err_held", 32'(bus.err_sticky), 1);

    // 5: rd==0 results are consumed but never written; x0 never goes busy
    bus.lu_issue = 1; bus.lu_issue_rd = 5'd9;
    bus.alu_valid = 1; bus.alu_rd = 5'd0; bus.alu_data = 32'h55;
    bus.lu_valid = 1; bus.lu_rd = 5'd0; bus.lu_data = 32'h66;
    @(posedge clk);
    @(negedge clk);
    idle();
    bus.lu_issue = 1; bus.lu_issue_rd = 5'd0;
    @(posedge clk);
    @(negedge clk);
    idle();
    check("rd0_busy", bus.busy_mask, 32'h0000_0200);
    bus.chk_rd = 5'd9;
    #1;
    check("haz_rd9", 32'(bus.hazard), 1);
    bus.chk_rd = 5'd0;
    #1;
    check("haz_x0", 32'(bus.hazard), 0);
    tick();
    check("rd0_drained", 32'(bus.lu_ready), 1);
    check("rd0_busy_kept", bus.busy_mask, 32'h0000_0200);

    // 6: async reset with entries queued and registers busy
    for (int k = 1; k <= 3; k++) begin
      bus.alu_valid = 1; bus.alu_rd = 5'(10 + k); bus.alu_data = 32'hC000_0000 | 32'(k);
      bus.lu_valid = 1; bus.lu_rd = 5'(16 + k); bus.lu_data = 32'hD000_0000 | 32'(k);
      bus.lu_issue = 1; bus.lu_issue_rd = 5'(16 + k);
      if (k < 3) expect_wr(cyc + 1, 5'(10 + k), 32'hC000_0000 | 32'(k));
      @(posedge clk);
      if (k < 3) @(negedge clk);
      if (k == 2) check("busy_prerst", bus.busy_mask, 32'h0006_0200);
    end
    #1;
    rst = 1'b1;
    idle();
    #1;
    check("arst_regwrite", 32'(bus.RegWrite), 0);
    check("arst_busy", bus.busy_mask, 0);
    check("arst_full", 32'(bus.fifo_full), 0);
    check("arst_err", 32'(bus.err_sticky), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick();
    check("post_rst_busy", bus.busy_mask, 0);
    check("post_rst_ready", 32'(bus.lu_ready), 1);
    bus.alu_valid = 1; bus.alu_rd = 5'd6; bus.alu_data = 32'h0000_600D;
    expect_wr(cyc + 1, 5'd6, 32'h0000_600D);
    tick();
    idle();
    repeat (3) tick();

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
